// File: rtl/imm_enc.sv
// imm_enc: splices an immediate into a base instruction word according to the
// selected format and queues the result in a 2-entry FIFO.
// The optional range checking is enabled with the macro IMM_ENC_RANGE_CHECK_EN.
// Without that macro, out_err and err_cnt are tied to zero.
module imm_enc (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] imm_val,
   input  logic [2:0]  imm_sel,
   input  logic [31:0] base_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr_out,
   output logic        out_err,
   output logic [7:0]  err_cnt
);

   logic [31:0] enc_instr;
   logic [31:0] mem_instr [0:1];
   logic        wr_ptr_reg;
   logic        rd_ptr_reg;
   logic [1:0]  count_reg;
   logic [1:0]  count_next;
   logic        ready_reg;
   logic        push;
   logic        pop;

   // Overwrite only the immediate field of the selected format; illegal selects pass the base through
   always_comb begin
      enc_instr = base_instr;
      case (imm_sel)
         3'b000: enc_instr[31:20] = imm_val[11:0];
         3'b001: enc_instr[24:20] = imm_val[4:0];
         3'b010: begin
            enc_instr[31:25] = imm_val[11:5];
            enc_instr[11:7]  = imm_val[4:0];
         end
         3'b011: begin
            enc_instr[31]    = imm_val[12];
            enc_instr[7]     = imm_val[11];
            enc_instr[30:25] = imm_val[10:5];
            enc_instr[11:8]  = imm_val[4:1];
         end
         3'b100: enc_instr[31:12] = imm_val[31:12];
         3'b101: begin
            enc_instr[31]    = imm_val[20];
            enc_instr[30:21] = imm_val[10:1];
            enc_instr[20]    = imm_val[11];
            enc_instr[19:12] = imm_val[19:12];
         end
         default: enc_instr = base_instr;
      endcase
   end

   // in_ready comes from a register, so push never depends on out_ready combinationally
   assign push       = in_valid & ready_reg;
   assign pop        = (count_reg != 2'd0) & out_ready;
   assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

   // FIFO pointers, occupancy and the registered ready flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         ready_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         ready_reg <= (count_next != 2'd2);
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      end
   end

   // Entry storage; contents are qualified by occupancy, so they need no reset
   always_ff @(posedge clk) begin
      if (push) mem_instr[wr_ptr_reg] <= enc_instr;
   end

   assign in_ready  = ready_reg;
   assign out_valid = (count_reg != 2'd0);
   assign instr_out = out_valid ? mem_instr[rd_ptr_reg] : 32'd0;

`ifdef IMM_ENC_RANGE_CHECK_EN
   logic       enc_err;
   logic       mem_err [0:1];
   logic [7:0] err_cnt_reg;

   // Flag immediates that the selected format cannot represent exactly
   always_comb begin
      enc_err = 1'b0;
      case (imm_sel)
         3'b000, 3'b010: enc_err = (imm_val[31:11] != {21{imm_val[11]}});
         3'b001:         enc_err = (imm_val[31:5] != 27'd0);
         3'b011:         enc_err = (imm_val[31:12] != {20{imm_val[12]}}) | imm_val[0];
         3'b100:         enc_err = (imm_val[11:0] != 12'd0);
         3'b101:         enc_err = (imm_val[31:20] != {12{imm_val[20]}}) | imm_val[0];
         default:        enc_err = 1'b1;
      endcase
   end

   // Error flag travels with its entry
   always_ff @(posedge clk) begin
      if (push) mem_err[wr_ptr_reg] <= enc_err;
   end

   // Saturating count of accepted errored requests
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_reg <= 8'd0;
      end else if (push && enc_err && (err_cnt_reg != 8'hFF)) begin
         err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   assign out_err = out_valid ? mem_err[rd_ptr_reg] : 1'b0;
   assign err_cnt = err_cnt_reg;
`else
   assign out_err = 1'b0;
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// tb_imm_enc: directed and randomized checks of imm_enc against a queue-based
// reference model; follows IMM_ENC_RANGE_CHECK_EN when computing error expectations.
module tb_imm_enc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] imm_val;
   logic [2:0]  imm_sel;
   logic [31:0] base_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr_out;
   logic        out_err;
   logic [7:0]  err_cnt;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] q_instr [$];
   logic        q_err [$];
   int          model_cnt = 0;
   bit          ready_en  = 1'b0;

   imm_enc dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .imm_val(imm_val), .imm_sel(imm_sel), .base_instr(base_instr),
      .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
      .out_err(out_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Reference encoding: clear the field mask, then OR in shifted immediate pieces
   function automatic logic [31:0] enc_model(input logic [31:0] imm, input logic [2:0] sel,
                                             input logic [31:0] base);
      logic [31:0] mask;
      logic [31:0] field;
      mask  = 32'd0;
      field = 32'd0;
      case (sel)
         3'd0: begin mask = 32'hFFF0_0000; field = (imm & 32'hFFF) << 20; end
         3'd1: begin mask = 32'h01F0_0000; field = (imm & 32'h1F) << 20; end
         3'd2: begin
            mask  = 32'hFE00_0F80;
            field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
         end
         3'd3: begin
            mask  = 32'hFE00_0F80;
            field = (((imm >> 12) & 32'h1) << 31) | (((imm >> 11) & 32'h1) << 7) |
                    (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
         end
         3'd4: begin mask = 32'hFFFF_F000; field = imm & 32'hFFFF_F000; end
         3'd5: begin
            mask  = 32'hFFFF_F000;
            field = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                    (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
         end
         default: begin mask = 32'd0; field = 32'd0; end
      endcase
      return (base & ~mask) | field;
   endfunction

   // True when the signed value lies in the n-bit two's complement range
   function automatic bit fits(input logic [31:0] imm, input int n);
      longint s;
      s = longint'($signed(imm));
      return (s >= -(longint'(1) << (n - 1))) && (s < (longint'(1) << (n - 1)));
   endfunction

   function automatic bit err_model(input logic [31:0] imm, input logic [2:0] sel);
`ifdef IMM_ENC_RANGE_CHECK_EN
      case (sel)
         3'd0, 3'd2: return !fits(imm, 12);
         3'd1:       return imm > 32'd31;
         3'd3:       return !fits(imm, 13) || (imm % 2 == 1);
         3'd4:       return (imm % 4096) != 0;
         3'd5:       return !fits(imm, 21) || (imm % 2 == 1);
         default:    return 1'b1;
      endcase
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs against the model, update the model, advance the clock
   task automatic step(input string tag);
      bit exp_rdy;
      #1;
      exp_rdy = ready_en && (q_instr.size() != 2);
      chk({tag, ":in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
      chk({tag, ":out_valid"}, {31'd0, out_valid}, {31'd0, q_instr.size() != 0});
      chk({tag, ":err_cnt"}, {24'd0, err_cnt}, model_cnt);
      if (q_instr.size() != 0) begin
         chk({tag, ":instr_out"}, instr_out, q_instr[0]);
         chk({tag, ":out_err"}, {31'd0, out_err}, {31'd0, q_err[0]});
         if (out_ready) begin
            void'(q_instr.pop_front());
            void'(q_err.pop_front());
         end
      end else begin
         chk({tag, ":idle_instr"}, instr_out, 32'd0);
         chk({tag, ":idle_err"}, {31'd0, out_err}, 32'd0);
      end
      if (in_valid && exp_rdy) begin
         q_instr.push_back(enc_model(imm_val, imm_sel, base_instr));
         q_err.push_back(err_model(imm_val, imm_sel));
         if (err_model(imm_val, imm_sel) && model_cnt < 255) model_cnt++;
      end
      @(posedge clk);
      if (!rst) ready_en = 1'b1;
      #1;
      $display("step %s: in_valid=%0b in_ready=%0b out_valid=%0b out_ready=%0b instr_out=%h out_err=%0b err_cnt=%0d",
               tag, in_valid, in_ready, out_valid, out_ready, instr_out, out_err, err_cnt);
   endtask

   task automatic drive(input logic v, input logic [31:0] imm, input logic [2:0] sel,
                        input logic [31:0] base);
      in_valid   = v;
      imm_val    = imm;
      imm_sel    = sel;
      base_instr = base;
   endtask

   initial begin
      logic [31:0] r;
      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 32'd0, 3'd0, 32'd0);
      #2;
      chk("reset:out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset:in_ready", {31'd0, in_ready}, 32'd0);
      chk("reset:instr_out", instr_out, 32'd0);
      chk("reset:err_cnt", {24'd0, err_cnt}, 32'd0);
      #10;
      rst = 1'b0;
      @(posedge clk);
      ready_en = 1'b1;
      #1;

      // Directed format examples
      drive(1'b1, 32'hFFFF_F800, 3'd0, 32'h0000_0013);
      step("I");
      drive(1'b1, 32'h0000_0010, 3'd3, 32'h0000_0063);
      chk("I:literal", instr_out, 32'h8000_0013);
      chk("I:literal_err", {31'd0, out_err}, 32'd0);
      step("B");
      drive(1'b1, 32'h0000_0801, 3'd5, 32'h0000_006F);
      chk("B:literal", instr_out, 32'h0000_0863);
      step("J");
      drive(1'b0, 32'd0, 3'd0, 32'd0);
      chk("J:literal", instr_out, 32'h0010_006F);
`ifdef IMM_ENC_RANGE_CHECK_EN
      chk("J:literal_err", {31'd0, out_err}, 32'd1);
      chk("J:literal_cnt", {24'd0, err_cnt}, 32'd1);
`else
      chk("J:literal_err", {31'd0, out_err}, 32'd0);
`endif
      step("drain");

      // Backpressure: A and B fill the FIFO, C is held until the consumer resumes
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0123, 3'd0, 32'h0000_0013);
      step("bp_A");
      drive(1'b1, 32'h0000_0040, 3'd2, 32'h0000_0023);
      step("bp_B");
      drive(1'b1, 32'h1234_5000, 3'd4, 32'h0000_0037);
      step("bp_C");
      step("bp_C_hold");
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step("bp_drain");
         drive(1'b0, 32'd0, 3'd0, 32'd0);
      end

      // Randomized traffic with boundary-biased immediates
      for (int i = 0; i < 400; i++) begin
         r = $urandom;
         case ($urandom_range(0, 5))
            0: r = $urandom_range(0, 64);
            1: r = 32'hFFFF_FFFF - $urandom_range(0, 64);
            2: r = 32'h0000_07FF + $urandom_range(0, 2);
            3: r = 32'hFFFF_F7FF + $urandom_range(0, 2);
            4: r = 32'h000F_FFFE + $urandom_range(0, 4);
            default: ;
         endcase
         drive($urandom_range(0, 3) != 0, r, 3'($urandom_range(0, 7)), $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step("rand");
      end

      // Saturation with illegal selects
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, $urandom, 3'd7, $urandom);
         step("sat");
      end
`ifdef IMM_ENC_RANGE_CHECK_EN
      chk("sat:literal", {24'd0, err_cnt}, 32'd255);
`else
      chk("sat:literal", {24'd0, err_cnt}, 32'd0);
`endif

      // Reset mid-operation with a full FIFO
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0003, 3'd3, 32'h0000_0063);
      step("full_1");
      step("full_2");
      #3;
      rst = 1'b1;
      #1;
      chk("midrst:out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst:in_ready", {31'd0, in_ready}, 32'd0);
      chk("midrst:instr_out", instr_out, 32'd0);
      chk("midrst:err_cnt", {24'd0, err_cnt}, 32'd0);
      q_instr.delete();
      q_err.delete();
      model_cnt = 0;
      ready_en  = 1'b0;
      drive(1'b0, 32'd0, 3'd0, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      out_ready = 1'b1;
      step("post_rst");
      drive(1'b1, 32'h0000_0005, 3'd1, 32'h4000_5013);
      step("post_req");
      drive(1'b0, 32'd0, 3'd0, 32'd0);
      chk("post_req:literal", instr_out, 32'h4050_5013);
      step("post_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/imm_enc.md
IMM_ENC -- requirements
Module: imm_enc

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have ports, one per line:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- imm_val  in  32  immediate value to encode, two's complement
- imm_sel  in  3  format: 000 I, 001 I*(shamt), 010 S, 011 B, 100 U, 101 J, 110/111 illegal
- base_instr  in  32  instruction word supplying all non-immediate bits
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- instr_out  out  32  encoded instruction word
- out_err  out  1  immediate not representable in the selected format
- err_cnt  out  8  saturating count of accepted requests with error

Function
REQ-003 SHALL build instr_out from base_instr, overwriting only the immediate bits of the selected format:
- I: [31:20]=imm[11:0].
- I*: [24:20]=imm[4:0]; [31:25] from base.
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
- U: [31:12]=imm[31:12].
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-004 SHALL pass base_instr unchanged for illegal imm_sel (110/111).
REQ-005 SHALL buffer results in a 2-entry FIFO; a request accepted in cycle N is visible at the FIFO head no earlier than cycle N+1.
REQ-006 SHALL drive in_ready = (occupancy != 2), registered, with no combinational path from out_ready.
REQ-007 SHALL hold out_valid, instr_out and out_err stable while out_valid & !out_ready.
REQ-008 SHALL, on a simultaneous push and pop at occupancy 1, keep occupancy 1 and present the newer entry next cycle.
REQ-009 SHALL deliver entries strictly in acceptance order, with no loss or duplication.
REQ-010 SHALL drive instr_out and out_err to 0 when out_valid=0.
REQ-011 SHALL NOT stall on error; errored entries flow through the FIFO like any other entry.

Reset
REQ-012 SHALL, while rst=1, immediately force: occupancy 0, out_valid=0, in_ready=0, instr_out=0, out_err=0, err_cnt=0.
REQ-013 SHALL raise in_ready in the first clock edge after rst deasserts; entries held at reset are discarded.

Configuration
REQ-014 SHALL use macro IMM_ENC_RANGE_CHECK_EN.
REQ-015 With the macro defined, SHALL set the entry's out_err when any of these hold:
- I/S: imm_val is not a sign-extended 12-bit value.
- I*: imm[31:5] != 0.
- B: imm_val is not a sign-extended 13-bit value, or imm[0]=1.
- U: imm[11:0] != 0.
- J: imm_val is not a sign-extended 21-bit value, or imm[0]=1.
- imm_sel is illegal.
It SHALL increment err_cnt by 1 per accepted errored request, saturating at 255.
REQ-016 Without the macro, SHALL tie out_err=0 and err_cnt=0 and include no checking logic; encoding is unchanged.

Verification
REQ-017 I: imm_val=0xFFFFF800, sel=000, base=0x00000013, out_ready=1 -> next cycle out_valid=1, instr_out=0x80000013, out_err=0.
REQ-018 B: imm_val=0x00000010, sel=011, base=0x00000063 -> instr_out=0x00000863, out_err=0.
REQ-019 J odd offset (macro on): imm_val=0x00000801, sel=101, base=0x0000006F -> instr_out=0x0010006F, out_err=1, err_cnt 0->1.
REQ-020 Backpressure: out_ready=0, three back-to-back requests A,B,C -> in_ready low after A,B accepted; C held; raise out_ready -> A,B,C delivered in order, none lost.
REQ-021 Reset mid-operation: FIFO full, err_cnt=5, assert rst between clock edges -> out_valid=0, err_cnt=0 without waiting for a clock edge; after release, a new request passes normally.
REQ-022 Saturation (macro on): 300 accepted requests with sel=111 -> err_cnt=255, no wrap; with macro off -> err_cnt=0, out_err=0 throughout.
